// File: rtl/disk_controller_if.sv
// Command, status and data-stream signals of the disk controller.
// The master modport is the host side; the slave modport is the controller.
interface disk_controller_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int PROC_BITS  = 4,
  parameter int LEN_WIDTH  = 8
);
  // Streams use valid/ready: a beat transfers on a rising edge where both are 1;
  // the sender holds data and valid stable until that edge.
  logic                             req;
  logic                             cmd_write;
  logic [PROC_BITS-1:0]             proc_id;
  logic [ADDR_WIDTH-PROC_BITS-1:0]  offset;
  logic [LEN_WIDTH-1:0]             length;
  logic                             busy;
  logic                             done;
  logic                             err;
  logic [DATA_WIDTH-1:0]            wr_data;
  logic                             wr_valid;
  logic                             wr_ready;
  logic [DATA_WIDTH-1:0]            rd_data;
  logic                             rd_valid;
  logic                             rd_ready;

  modport master (
    output req, cmd_write, proc_id, offset, length, wr_data, wr_valid, rd_ready,
    input  busy, done, err, wr_ready, rd_data, rd_valid
  );

  modport slave (
    input  req, cmd_write, proc_id, offset, length, wr_data, wr_valid, rd_ready,
    output busy, done, err, wr_ready, rd_data, rd_valid
  );
endinterface

// File: rtl/disk_controller.sv
// Burst disk controller: per-process regions, fixed seek latency, then a
// valid/ready write or read stream over an internal word array.
module disk_controller #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 12,
  parameter int PROC_BITS   = 4,
  parameter int SEEK_CYCLES = 4,
  parameter int LEN_WIDTH   = 8
) (
  input  logic                clk,
  input  logic                reset,
  disk_controller_if.slave    bus,
  output logic [1:0]          dbg_state
);
  localparam int OFF_W  = ADDR_WIDTH - PROC_BITS;
  localparam int REGION = 2 ** OFF_W;
  localparam int DEPTH  = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {ST_IDLE, ST_SEEK, ST_XFER, ST_DONE} state_t;

  state_t                 state_q, state_d;
  logic                   write_q, write_d;
  logic [PROC_BITS-1:0]   proc_q, proc_d;
  logic [OFF_W-1:0]       off_q, off_d;
  logic [LEN_WIDTH-1:0]   left_q, left_d;
  logic [3:0]             seek_q, seek_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   wr_ready_q, wr_ready_d;
  logic                   rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0]  rd_data_q, rd_data_d;

  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic                   mem_we;
  logic [ADDR_WIDTH-1:0]  mem_waddr;
  logic [31:0]            end_off;
  logic                   cmd_bad;
  logic                   beat_done;

  assign end_off = 32'(bus.offset) + 32'(bus.length);
  assign cmd_bad = (bus.length == '0) || (end_off > 32'(REGION));

  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    proc_d     = proc_q;
    off_d      = off_q;
    left_d     = left_q;
    seek_d     = seek_q;
    err_d      = 1'b0;
    wr_ready_d = wr_ready_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    mem_we     = 1'b0;
    mem_waddr  = {proc_q, off_q};
    beat_done  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          if (cmd_bad) begin
            err_d = 1'b1;
          end else begin
            state_d = ST_SEEK;
            write_d = bus.cmd_write;
            proc_d  = bus.proc_id;
            off_d   = bus.offset;
            left_d  = bus.length;
            seek_d  = 4'(SEEK_CYCLES - 1);
          end
        end
      end
      ST_SEEK: begin
        if (seek_q == 4'd0) begin
          state_d = ST_XFER;
          // Reads prefetch the first word so rd_valid rises with valid data.
          if (write_q) begin
            wr_ready_d = 1'b1;
          end else begin
            rd_valid_d = 1'b1;
            rd_data_d  = mem[{proc_q, off_q}];
          end
        end else begin
          seek_d = seek_q - 4'd1;
        end
      end
      ST_XFER: begin
        if (write_q) begin
          if (bus.wr_valid && wr_ready_q) begin
            mem_we    = 1'b1;
            beat_done = 1'b1;
          end
        end else if (rd_valid_q && bus.rd_ready) begin
          beat_done = 1'b1;
          if (left_q != LEN_WIDTH'(1)) begin
            rd_data_d = mem[{proc_q, off_q + OFF_W'(1)}];
          end
        end
        if (beat_done) begin
          off_d  = off_q + OFF_W'(1);
          left_d = left_q - LEN_WIDTH'(1);
          if (left_q == LEN_WIDTH'(1)) begin
            state_d    = ST_DONE;
            wr_ready_d = 1'b0;
            rd_valid_d = 1'b0;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      write_q    <= 1'b0;
      proc_q     <= '0;
      off_q      <= '0;
      left_q     <= '0;
      seek_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      wr_ready_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      proc_q     <= proc_d;
      off_q      <= off_d;
      left_q     <= left_d;
      seek_q     <= seek_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      wr_ready_q <= wr_ready_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Storage survives reset; a beat coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem[mem_waddr] <= bus.wr_data;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.wr_ready = wr_ready_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
  assign dbg_state    = state_q;
endmodule
